// File: rtl/mem_stage.sv
// MEM stage: data-bus access, load alignment/extension, AdEL/AdES detection.
// Define MEM_LWLR_EN to enable the lwl/lwr unaligned word loads.
module mem_stage #(
    parameter int PASS_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EXE_over,
    output logic              MEM_allow_in,
    output logic              MEM_valid,
    output logic              MEM_over,
    input  logic              WB_allow_in,
    input  logic              cancel,
    input  logic [2:0]        exe_ld_op,
    input  logic [1:0]        exe_st_op,
    input  logic [31:0]       exe_addr,
    input  logic [31:0]       exe_st_data,
    input  logic [31:0]       exe_rt_old,
    input  logic [31:0]       exe_result,
    input  logic [PASS_W-1:0] exe_side,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       mem_result,
    output logic [3:0]        mem_wbytes,
    output logic              mem_adel,
    output logic              mem_ades,
    output logic [31:0]       mem_badvaddr,
    output logic [PASS_W-1:0] mem_side
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic        discard;
    logic        discard_n;
    logic [2:0]  ld_q;
    logic [1:0]  st_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
`ifdef MEM_LWLR_EN
    logic [31:0] rt_q;
`endif

    logic ld_byte;
    logic ld_half;
    logic ld_word;
    logic ld_lr;
    logic st_any;
    logic ld_fault;
    logic st_fault;
    logic fault;
    logic lr_bus;
    logic need_bus;
    logic accept;
    logic handoff;
    logic rd_done;
    logic squash;

    assign ld_byte = (exe_ld_op == 3'd1) || (exe_ld_op == 3'd2);
    assign ld_half = (exe_ld_op == 3'd3) || (exe_ld_op == 3'd4);
    assign ld_word = (exe_ld_op == 3'd5);
    assign ld_lr   = (exe_ld_op == 3'd6) || (exe_ld_op == 3'd7);
    assign st_any  = (exe_st_op != 2'd0);

    assign ld_fault = (ld_half & exe_addr[0])
                    | (ld_word & (|exe_addr[1:0]));
    assign st_fault = ((exe_st_op == 2'd2) & exe_addr[0])
                    | ((exe_st_op == 2'd3) & (|exe_addr[1:0]));
    assign fault    = ld_fault | st_fault;

`ifdef MEM_LWLR_EN
    assign lr_bus = ld_lr;
`else
    assign lr_bus = 1'b0;
`endif

    assign need_bus = ~fault
                    & (ld_byte | ld_half | ld_word | st_any | lr_bus);

    assign MEM_over     = MEM_valid
                        & ((state == S_IDLE) | (state == S_DONE));
    assign handoff      = MEM_over & WB_allow_in;
    assign MEM_allow_in = ~discard & (~MEM_valid | handoff);
    // a flush in the same cycle wins over the incoming instruction
    assign accept       = EXE_over & MEM_allow_in & ~cancel;

    assign rd_done = ((state == S_REQ) & data_addr_ok & data_data_ok)
                   | ((state == S_WAIT) & data_data_ok);
    assign squash  = discard | cancel;

    always_comb begin
        state_n   = state;
        discard_n = discard;
        case (state)
            S_IDLE: begin
                if (accept & need_bus) state_n = S_REQ;
            end
            S_REQ: begin
                discard_n = squash;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_n   = squash ? S_IDLE : S_DONE;
                        discard_n = 1'b0;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                discard_n = squash;
                if (data_data_ok) begin
                    state_n   = squash ? S_IDLE : S_DONE;
                    discard_n = 1'b0;
                end
            end
            S_DONE: begin
                if (cancel) begin
                    state_n = S_IDLE;
                end else if (WB_allow_in) begin
                    state_n = (accept & need_bus) ? S_REQ : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // bus request fields come from registers, so they hold until addr_ok
    assign data_req = (state == S_REQ);
    assign data_wr  = (st_q != 2'd0);

    always_comb begin
        data_size  = 2'd2;
        data_addr  = addr_q;
        data_wdata = sdata_q;
        data_wstrb = 4'b0000;
        if ((ld_q == 3'd1) || (ld_q == 3'd2) || (st_q == 2'd1)) begin
            data_size = 2'd0;
        end else if ((ld_q == 3'd3) || (ld_q == 3'd4)
                     || (st_q == 2'd2)) begin
            data_size = 2'd1;
        end
`ifdef MEM_LWLR_EN
        if ((ld_q == 3'd6) || (ld_q == 3'd7)) begin
            data_addr = {addr_q[31:2], 2'b00};
        end
`endif
        case (st_q)
            2'd1: begin
                data_wstrb = 4'b0001 << addr_q[1:0];
                data_wdata = {4{sdata_q[7:0]}};
            end
            2'd2: begin
                data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{sdata_q[15:0]}};
            end
            2'd3: data_wstrb = 4'b1111;
            default: ;
        endcase
    end

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;
    logic [3:0]  ld_wb;
`ifdef MEM_LWLR_EN
    logic [31:0] lr_sh;
    logic [31:0] lr_mask;
`endif

    always_comb begin
        ld_b   = data_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_h   = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        ld_val = data_rdata;
        ld_wb  = 4'hF;
`ifdef MEM_LWLR_EN
        lr_sh   = data_rdata;
        lr_mask = 32'hFFFF_FFFF;
`endif
        case (ld_q)
            3'd1: ld_val = {{24{ld_b[7]}}, ld_b};
            3'd2: ld_val = {24'd0, ld_b};
            3'd3: ld_val = {{16{ld_h[15]}}, ld_h};
            3'd4: ld_val = {16'd0, ld_h};
`ifdef MEM_LWLR_EN
            3'd6: begin
                lr_sh = data_rdata << {~addr_q[1:0], 3'b000};
                ld_wb = 4'hF << ~addr_q[1:0];
            end
            3'd7: begin
                lr_sh = data_rdata >> {addr_q[1:0], 3'b000};
                ld_wb = 4'hF >> addr_q[1:0];
            end
`endif
            default: ;
        endcase
`ifdef MEM_LWLR_EN
        if ((ld_q == 3'd6) || (ld_q == 3'd7)) begin
            lr_mask = {{8{ld_wb[3]}}, {8{ld_wb[2]}},
                       {8{ld_wb[1]}}, {8{ld_wb[0]}}};
            ld_val  = (lr_sh & lr_mask) | (rt_q & ~lr_mask);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            discard      <= 1'b0;
            MEM_valid    <= 1'b0;
            ld_q         <= 3'd0;
            st_q         <= 2'd0;
            addr_q       <= 32'd0;
            sdata_q      <= 32'd0;
`ifdef MEM_LWLR_EN
            rt_q         <= 32'd0;
`endif
            mem_result   <= 32'd0;
            mem_wbytes   <= 4'd0;
            mem_adel     <= 1'b0;
            mem_ades     <= 1'b0;
            mem_badvaddr <= 32'd0;
            mem_side     <= '0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (cancel) begin
                MEM_valid <= 1'b0;
            end else if (accept) begin
                MEM_valid <= 1'b1;
            end else if (handoff) begin
                MEM_valid <= 1'b0;
            end
            if (accept) begin
                ld_q         <= exe_ld_op;
                st_q         <= exe_st_op;
                addr_q       <= exe_addr;
                sdata_q      <= exe_st_data;
`ifdef MEM_LWLR_EN
                rt_q         <= exe_rt_old;
`endif
                mem_adel     <= ld_fault;
                mem_ades     <= st_fault;
                mem_badvaddr <= fault ? exe_addr : 32'd0;
                mem_side     <= exe_side;
                // disabled lwl/lwr keep the old rt value with no byte writes
                mem_result   <= ld_lr ? exe_rt_old : exe_result;
                mem_wbytes   <= (fault | st_any | ld_lr) ? 4'd0 : 4'hF;
            end
            if (rd_done & ~squash & (ld_q != 3'd0)) begin
                mem_result <= ld_val;
                mem_wbytes <= ld_wb;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops, bus responder, WB monitor.
// Build with +define+MEM_LWLR_EN to cover the lwl/lwr path.
module tb_mem_stage;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          EXE_over;
    logic          MEM_allow_in;
    logic          MEM_valid;
    logic          MEM_over;
    logic          WB_allow_in;
    logic          cancel;
    logic [2:0]    exe_ld_op;
    logic [1:0]    exe_st_op;
    logic [31:0]   exe_addr;
    logic [31:0]   exe_st_data;
    logic [31:0]   exe_rt_old;
    logic [31:0]   exe_result;
    logic [PW-1:0] exe_side;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [31:0]   data_addr;
    logic [31:0]   data_wdata;
    logic [3:0]    data_wstrb;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic [31:0]   mem_result;
    logic [3:0]    mem_wbytes;
    logic          mem_adel;
    logic          mem_ades;
    logic [31:0]   mem_badvaddr;
    logic [PW-1:0] mem_side;

    always #5 clk = ~clk;

    mem_stage #(.PASS_W(PW)) dut (
        .clk(clk), .reset(reset), .EXE_over(EXE_over),
        .MEM_allow_in(MEM_allow_in), .MEM_valid(MEM_valid),
        .MEM_over(MEM_over), .WB_allow_in(WB_allow_in),
        .cancel(cancel), .exe_ld_op(exe_ld_op),
        .exe_st_op(exe_st_op), .exe_addr(exe_addr),
        .exe_st_data(exe_st_data), .exe_rt_old(exe_rt_old),
        .exe_result(exe_result), .exe_side(exe_side),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .mem_result(mem_result),
        .mem_wbytes(mem_wbytes), .mem_adel(mem_adel),
        .mem_ades(mem_ades), .mem_badvaddr(mem_badvaddr),
        .mem_side(mem_side)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  wb;
        logic        adel;
        logic        ades;
        logic [31:0] badv;
        logic [63:0] side;
        bit          chkres;
        bit          lat1;
        int          acc;
    } wb_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          alat;
        int          dlat;
    } bus_t;

    wb_t  sb[$];
    bus_t bq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   reqs = 0;
    int   exp_reqs = 0;
    int   tag = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // WB-side monitor: one pop per completed handshake
    wb_t mon_e;
    always @(negedge clk) begin
        if (!reset && MEM_valid && MEM_over && WB_allow_in) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_over actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chkres) chk("result", mem_result, mon_e.res);
                chk("wbytes", mem_wbytes, mon_e.wb);
                chk("adel", mem_adel, mon_e.adel);
                chk("ades", mem_ades, mon_e.ades);
                if (mon_e.adel || mon_e.ades)
                    chk("badvaddr", mem_badvaddr, mon_e.badv);
                chk("side", mem_side, mon_e.side);
                if (mon_e.lat1) chk("latency", cyc, mon_e.acc);
            end
        end
    end

    // SRAM-like responder driven by the expected-request queue
    bus_t bb;
    initial begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset && data_req) begin
                reqs++;
                if (bq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=1 required=0");
                    bb.alat  = 0;
                    bb.dlat  = 0;
                    bb.rdata = 32'd0;
                end else begin
                    bb = bq.pop_front();
                    chk("bus_wr", data_wr, bb.wr);
                    chk("bus_size", data_size, bb.size);
                    chk("bus_addr", data_addr, bb.addr);
                    if (bb.wr) begin
                        chk("bus_wstrb", data_wstrb, bb.strb);
                        chk("bus_wdata", data_wdata, bb.wdata);
                    end
                end
                repeat (bb.alat) @(posedge clk);
                #1 data_addr_ok = 1'b1;
                if (bb.dlat == 0) begin
                    data_data_ok = 1'b1;
                    data_rdata   = bb.rdata;
                end
                @(posedge clk);
                #1 data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                if (bb.dlat > 0) begin
                    repeat (bb.dlat - 1) @(posedge clk);
                    #1 data_data_ok = 1'b1;
                    data_rdata = bb.rdata;
                    @(posedge clk);
                    #1 data_data_ok = 1'b0;
                end
            end
        end
    end

    task automatic issue(
        input logic [2:0] ld, input logic [1:0] st,
        input logic [31:0] addr, input logic [31:0] sd,
        input logic [31:0] rt, input logic [31:0] alu,
        input bit has_bus, input bus_t b,
        input bit push, input wb_t e);
        bit acc;
        tag++;
        EXE_over    = 1'b1;
        exe_ld_op   = ld;
        exe_st_op   = st;
        exe_addr    = addr;
        exe_st_data = sd;
        exe_rt_old  = rt;
        exe_result  = alu;
        exe_side    = {32'(tag), addr};
        e.side      = {32'(tag), addr};
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = MEM_allow_in && !cancel;
            @(posedge clk);
            #1;
        end
        EXE_over = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.acc = cyc;
            if (push) sb.push_back(e);
            if (has_bus) begin
                bq.push_back(b);
                exp_reqs++;
            end
        end
    endtask

    task automatic ld_op(
        input logic [2:0] ld, input logic [31:0] addr,
        input logic [31:0] rdata, input logic [31:0] rt,
        input int alat, input int dlat, input logic [1:0] size,
        input logic [31:0] baddr, input logic [31:0] eres,
        input logic [3:0] ewb, input bit push);
        bus_t b;
        wb_t  e;
        b.wr = 1'b0; b.size = size; b.addr = baddr;
        b.strb = 4'd0; b.wdata = 32'd0; b.rdata = rdata;
        b.alat = alat; b.dlat = dlat;
        e.res = eres; e.wb = ewb; e.adel = 1'b0; e.ades = 1'b0;
        e.badv = 32'd0; e.chkres = 1'b1; e.lat1 = 1'b0;
        issue(ld, 2'd0, addr, 32'h0, rt, 32'h0BAD_0BAD,
              1'b1, b, push, e);
    endtask

    task automatic st_op(
        input logic [1:0] st, input logic [31:0] addr,
        input logic [31:0] sd, input int alat, input int dlat,
        input logic [1:0] size, input logic [3:0] strb,
        input logic [31:0] wdata);
        bus_t b;
        wb_t  e;
        b.wr = 1'b1; b.size = size; b.addr = addr;
        b.strb = strb; b.wdata = wdata; b.rdata = 32'h0;
        b.alat = alat; b.dlat = dlat;
        e.res = 32'd0; e.wb = 4'd0; e.adel = 1'b0; e.ades = 1'b0;
        e.badv = 32'd0; e.chkres = 1'b0; e.lat1 = 1'b0;
        issue(3'd0, st, addr, sd, 32'h0, 32'h0, 1'b1, b, 1'b1, e);
    endtask

    task automatic imm_op(
        input logic [2:0] ld, input logic [1:0] st,
        input logic [31:0] addr, input logic [31:0] alu,
        input logic [31:0] eres, input logic [3:0] ewb,
        input logic eadel, input logic eades,
        input bit chkres, input bit lat1);
        bus_t b;
        wb_t  e;
        b.wr = 1'b0; b.size = 2'd0; b.addr = 32'd0;
        b.strb = 4'd0; b.wdata = 32'd0; b.rdata = 32'd0;
        b.alat = 0; b.dlat = 0;
        e.res = eres; e.wb = ewb; e.adel = eadel; e.ades = eades;
        e.badv = addr; e.chkres = chkres; e.lat1 = lat1;
        issue(ld, st, addr, 32'h5A5A_5A5A, 32'h0, alu,
              1'b0, b, 1'b1, e);
    endtask

    task automatic wait_drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !MEM_valid && !data_req;
        end
        chk(nm, ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    bit seen;

    initial begin
        reset       = 1'b1;
        EXE_over    = 1'b0;
        WB_allow_in = 1'b1;
        cancel      = 1'b0;
        exe_ld_op   = 3'd0;
        exe_st_op   = 2'd0;
        exe_addr    = 32'd0;
        exe_st_data = 32'd0;
        exe_rt_old  = 32'd0;
        exe_result  = 32'd0;
        exe_side    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", MEM_valid, 0);
        chk("rst_over", MEM_over, 0);
        chk("rst_req", data_req, 0);
        chk("rst_allow", MEM_allow_in, 1);
        chk("rst_result", mem_result, 0);
        chk("rst_wbytes", mem_wbytes, 0);
        chk("rst_adel", mem_adel, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        ld_op(3'd5, 32'h1000, 32'hDEAD_BEEF, 0, 1, 2, 2'd2,
              32'h1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
        ld_op(3'd1, 32'h1003, 32'h80FF_FF7F, 0, 0, 1, 2'd0,
              32'h1003, 32'hFFFF_FF80, 4'hF, 1'b1);
        ld_op(3'd2, 32'h1003, 32'h80FF_FF7F, 0, 1, 0, 2'd0,
              32'h1003, 32'h0000_0080, 4'hF, 1'b1);
        ld_op(3'd3, 32'h1002, 32'h80FF_FF7F, 0, 0, 0, 2'd1,
              32'h1002, 32'hFFFF_80FF, 4'hF, 1'b1);
        ld_op(3'd4, 32'h1000, 32'h80FF_FF7F, 0, 1, 1, 2'd1,
              32'h1000, 32'h0000_FF7F, 4'hF, 1'b1);
        st_op(2'd2, 32'h2002, 32'h1234_ABCD, 1, 1, 2'd1,
              4'b1100, 32'hABCD_ABCD);
        st_op(2'd1, 32'h2001, 32'h0000_00A5, 0, 0, 2'd0,
              4'b0010, 32'hA5A5_A5A5);
        st_op(2'd3, 32'h2004, 32'hCAFE_F00D, 0, 2, 2'd2,
              4'b1111, 32'hCAFE_F00D);
        wait_drain("drain_a");

        imm_op(3'd5, 2'd0, 32'h1002, 32'h77, 32'h0, 4'h0,
               1'b1, 1'b0, 1'b0, 1'b1);
        imm_op(3'd4, 2'd0, 32'h1001, 32'h77, 32'h0, 4'h0,
               1'b1, 1'b0, 1'b0, 1'b1);
        imm_op(3'd0, 2'd2, 32'h2001, 32'h77, 32'h0, 4'h0,
               1'b0, 1'b1, 1'b0, 1'b1);
        imm_op(3'd0, 2'd3, 32'h2006, 32'h77, 32'h0, 4'h0,
               1'b0, 1'b1, 1'b0, 1'b1);
        imm_op(3'd0, 2'd0, 32'h0, 32'h55AA_1234, 32'h55AA_1234,
               4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        ld_op(3'd1, 32'h1000, 32'h1234_5678, 0, 0, 0, 2'd0,
              32'h1000, 32'h0000_0078, 4'hF, 1'b1);
`ifdef MEM_LWLR_EN
        ld_op(3'd6, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344, 1, 1,
              2'd2, 32'h3000, 32'hCCDD_3344, 4'b1100, 1'b1);
        ld_op(3'd7, 32'h3002, 32'hAABB_CCDD, 32'h1122_3344, 0, 1,
              2'd2, 32'h3000, 32'h1122_AABB, 4'b0011, 1'b1);
`else
        imm_op(3'd6, 2'd0, 32'h3001, 32'h0, 32'h0, 4'h0,
               1'b0, 1'b0, 1'b0, 1'b1);
        imm_op(3'd7, 2'd0, 32'h3002, 32'h0, 32'h0, 4'h0,
               1'b0, 1'b0, 1'b0, 1'b1);
`endif
        wait_drain("drain_b");

        WB_allow_in = 1'b0;
        imm_op(3'd0, 2'd0, 32'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F,
               4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("stall_over", MEM_over, 1);
            chk("stall_allow", MEM_allow_in, 0);
        end
        @(posedge clk);
        #1 WB_allow_in = 1'b1;
        wait_drain("drain_c");

        ld_op(3'd5, 32'h1004, 32'h7777_7777, 0, 1, 4, 2'd2,
              32'h1004, 32'h0, 4'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = data_req && data_addr_ok;
        end
        chk("cx_addr_ok_seen", seen, 1);
        @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        chk("cx_allow_cancel", MEM_allow_in, 0);
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cx_valid_clear", MEM_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            chk("cx_allow_wait", MEM_allow_in, 0);
            seen = data_data_ok;
            if (!seen) @(negedge clk);
        end
        chk("cx_data_ok_seen", seen, 1);
        @(negedge clk);
        chk("cx_allow_idle", MEM_allow_in, 1);
        chk("cx_valid_idle", MEM_valid, 0);
        chk("cx_req_idle", data_req, 0);
        @(posedge clk);
        #1;

        ld_op(3'd5, 32'h1008, 32'h0123_4567, 0, 0, 1, 2'd2,
              32'h1008, 32'h0123_4567, 4'hF, 1'b1);
        wait_drain("drain_d");

        chk("req_count", reqs, exp_reqs);
        chk("bus_q_left", bq.size(), 0);
        chk("sb_q_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
